// File: rtl/snn_uart_tx.sv
// 8N1 serial transmitter with a small byte FIFO and runtime bit period.
// Define SNN_UART_TX_PARITY_EN to add a parity bit (cfg_parity_odd selects odd parity).
module snn_uart_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic [DIV_WIDTH-1:0]          cfg_div,
`ifdef SNN_UART_TX_PARITY_EN
  input  logic                          cfg_parity_odd,
`endif
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

`ifdef SNN_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t               state;
  logic [7:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [7:0]           shift;
  logic [2:0]           bit_cnt;
  logic [DIV_WIDTH-1:0] baud_cnt;
  logic [DIV_WIDTH-1:0] period;
`ifdef SNN_UART_TX_PARITY_EN
  logic                 parity;
`endif

  logic                 push;
  logic                 pop;
  logic                 baud_done;
  logic [DIV_WIDTH-1:0] eff_div;
  logic [7:0]           head;

  assign tx_ready  = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign push      = tx_valid && tx_ready;
  assign baud_done = (baud_cnt == '0);
  // A new frame may start from IDLE or on the very edge that ends STOP, so
  // back-to-back frames have no idle gap.
  assign pop       = ((state == S_IDLE) || ((state == S_STOP) && baud_done))
                     && (fifo_level != '0);
  assign busy      = (state != S_IDLE) || (fifo_level != '0);
  assign eff_div   = (cfg_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_div;
  assign head      = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and level need one,
  // and leaving it out lets the array map onto plain register-file cells.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state    <= S_IDLE;
      ser_tx   <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      period   <= DIV_WIDTH'(2);
`ifdef SNN_UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else if (pop) begin
      // Frame start: divisor (and parity mode) are frozen for the whole frame.
      state    <= S_START;
      ser_tx   <= 1'b0;
      shift    <= head;
      bit_cnt  <= '0;
      period   <= eff_div;
      baud_cnt <= eff_div - DIV_WIDTH'(1);
`ifdef SNN_UART_TX_PARITY_EN
      parity   <= (^head) ^ cfg_parity_odd;
`endif
    end else if (state != S_IDLE) begin
      if (!baud_done) begin
        baud_cnt <= baud_cnt - DIV_WIDTH'(1);
      end else begin
        baud_cnt <= period - DIV_WIDTH'(1);
        case (state)
          S_START: begin
            state  <= S_DATA;
            ser_tx <= shift[0];
          end
          S_DATA: begin
            if (bit_cnt == 3'd7) begin
`ifdef SNN_UART_TX_PARITY_EN
              state  <= S_PARITY;
              ser_tx <= parity;
`else
              state  <= S_STOP;
              ser_tx <= 1'b1;
`endif
            end else begin
              shift   <= shift >> 1;
              ser_tx  <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
`ifdef SNN_UART_TX_PARITY_EN
          S_PARITY: begin
            state  <= S_STOP;
            ser_tx <= 1'b1;
          end
`endif
          default: begin
            state  <= S_IDLE;
            ser_tx <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snn_uart_tx.sv
// Self-checking bench for snn_uart_tx: directed and random bytes compared
// against an expected line waveform built from the frame format.
module tb_snn_uart_tx;

  localparam int DEPTH = 4;
  localparam int DW    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          resetb;
  logic [DW-1:0] cfg_div;
  logic          cfg_parity_odd;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          ser_tx;
  logic          busy;
  logic [LW-1:0] fifo_level;

  int total = 0;
  int bad   = 0;

  bit         ser_q[$];
  bit         busy_q[$];
  bit         exp_bits[$];
  int         frame_ofs[$];
  logic [7:0] bq[$];

  snn_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
    .clock          (clock),
    .resetb         (resetb),
    .cfg_div        (cfg_div),
`ifdef SNN_UART_TX_PARITY_EN
    .cfg_parity_odd (cfg_parity_odd),
`endif
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .ser_tx         (ser_tx),
    .busy           (busy),
    .fifo_level     (fifo_level)
  );

  always #5 clock = ~clock;

  // One trace entry per rising edge, taken shortly after the edge.
  always @(posedge clock) begin
    #1;
    ser_q.push_back(ser_tx);
    busy_q.push_back(busy);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_samples(input int n);
    int budget = n - ser_q.size() + 20;
    while (ser_q.size() < n && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    check("wait_trace", (ser_q.size() >= n), 1);
  endtask

  task automatic wait_idle();
    int budget = 2000;
    while (busy !== 1'b0 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    check("wait_idle", busy, 0);
    repeat (3) @(negedge clock);
  endtask

  // Expected line for one frame: start, 8 data bits LSB first, [parity], stop.
  task automatic model_frame(input logic [7:0] b, input int div, input bit odd);
    int p = (div < 2) ? 2 : div;
    bit par;
    par = (($countones(b) % 2) == 1) ^ odd;
    frame_ofs.push_back(exp_bits.size());
    repeat (p) exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (p) exp_bits.push_back(((b >> i) & 8'd1) != 0);
`ifdef SNN_UART_TX_PARITY_EN
    repeat (p) exp_bits.push_back(par);
`endif
    repeat (p) exp_bits.push_back(1'b1);
  endtask

  task automatic model_clear();
    exp_bits.delete();
    frame_ofs.delete();
  endtask

  // Push bq on consecutive edges; s is the trace index of the first push edge.
  task automatic push_seq(input string tag, output int s);
    @(negedge clock);
    s = ser_q.size();
    for (int k = 0; k < bq.size(); k++) begin
      check($sformatf("%s_ready%0d", tag, k), tx_ready, 1);
      tx_valid = 1'b1;
      tx_data  = bq[k];
      @(negedge clock);
    end
    tx_valid = 1'b0;
  endtask

  task automatic check_frames(input string tag, input int f);
    int len = exp_bits.size();
    int lo, hi, mism, first;
    wait_samples(f + len + 1);
    if (ser_q.size() < f + len + 1) return;
    check({tag, "_line_high_on_push_edge"}, ser_q[f-1], 1);
    for (int k = 0; k < frame_ofs.size(); k++) begin
      lo = frame_ofs[k];
      hi = (k + 1 < frame_ofs.size()) ? frame_ofs[k+1] : len;
      mism = 0;
      first = -1;
      for (int i = lo; i < hi; i++) begin
        if (ser_q[f+i] !== exp_bits[i]) begin
          mism++;
          if (first < 0) first = i - lo;
        end
      end
      check($sformatf("%s_frame%0d_wrong_cycles_first_at_%0d", tag, k, first), mism, 0);
    end
    check({tag, "_busy_last_cycle"}, busy_q[f+len-1], 1);
    check({tag, "_busy_after_stop"}, busy_q[f+len], 0);
    check({tag, "_line_idle_after"}, ser_q[f+len], 1);
  endtask

  initial begin
    int s, n, r0, lows, busys;
    int d1;
    resetb = 1'b0; tx_valid = 1'b0; tx_data = '0; cfg_div = DW'(4); cfg_parity_odd = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ser_tx", ser_tx, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_level", fifo_level, 0);
    resetb = 1'b1;
    repeat (3) @(negedge clock);

    // Single byte, P=4: 40-cycle frame one cycle after the push edge.
    cfg_div = DW'(4);
    bq = '{8'hA5};
    push_seq("single", s);
    model_clear(); model_frame(8'hA5, 4, 1'b0);
    check_frames("single", s + 1);
    wait_idle();

    // Back-to-back into a full FIFO, P=8.
    cfg_div = DW'(8);
    bq = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'hF0};
    push_seq("btb", s);
    check("btb_level_full", fifo_level, 4);
    check("btb_ready_low_full", tx_ready, 0);
    tx_valid = 1'b1; tx_data = 8'h99;
    @(negedge clock);
    tx_valid = 1'b0;
    check("btb_push_when_full_ignored", fifo_level, 4);
    model_clear();
    foreach (bq[k]) model_frame(bq[k], 8, 1'b0);
    check_frames("btb", s + 1);
    wait_idle();

    // Push on the pop edge leaves the level at 1; both bytes go out in order.
    cfg_div = DW'(4);
    bq = '{8'h81, 8'h7E};
    push_seq("pushpop", s);
    check("pushpop_level", fifo_level, 1);
    model_clear(); model_frame(8'h81, 4, 1'b0); model_frame(8'h7E, 4, 1'b0);
    check_frames("pushpop", s + 1);
    wait_idle();

    // Divisor changed mid-frame only affects the following frame.
    cfg_div = DW'(4);
    bq = '{8'h3C, 8'hC3};
    push_seq("divchg", s);
    repeat (5) @(negedge clock);
    cfg_div = DW'(6);
    model_clear(); model_frame(8'h3C, 4, 1'b0); model_frame(8'hC3, 6, 1'b0);
    check_frames("divchg", s + 1);
    wait_idle();

    // Divisor clamp: 0 and 1 both give a 2-cycle bit.
    cfg_div = DW'(0);
    bq = '{8'h96};
    push_seq("clamp0", s);
    model_clear(); model_frame(8'h96, 0, 1'b0);
    check_frames("clamp0", s + 1);
    wait_idle();
    cfg_div = DW'(1);
    bq = '{8'h5A};
    push_seq("clamp1", s);
    model_clear(); model_frame(8'h5A, 1, 1'b0);
    check_frames("clamp1", s + 1);
    wait_idle();

`ifdef SNN_UART_TX_PARITY_EN
    cfg_div = DW'(4);
    cfg_parity_odd = 1'b0;
    bq = '{8'h03};
    push_seq("par_even", s);
    model_clear(); model_frame(8'h03, 4, 1'b0);
    check_frames("par_even", s + 1);
    wait_idle();
    cfg_parity_odd = 1'b1;
    bq = '{8'h07};
    push_seq("par_odd", s);
    model_clear(); model_frame(8'h07, 4, 1'b1);
    check_frames("par_odd", s + 1);
    wait_idle();
    cfg_parity_odd = 1'b0;
`endif

    // Random bursts of up to 4 bytes with random divisors.
    for (int r = 0; r < 4; r++) begin
      d1 = $urandom_range(0, 7);
      cfg_div = DW'(d1);
      n = $urandom_range(1, 4);
      bq.delete();
      repeat (n) bq.push_back(8'($urandom));
      push_seq($sformatf("rnd%0d", r), s);
      model_clear();
      foreach (bq[k]) model_frame(bq[k], d1, 1'b0);
      check_frames($sformatf("rnd%0d", r), s + 1);
      wait_idle();
    end

    // Reset during data bit 3 of 0xA5 (a 0 bit) aborts the frame.
    cfg_div = DW'(4);
    bq = '{8'hA5};
    push_seq("rstmid", s);
    wait_samples(s + 1 + 18);
    check("rstmid_bit3_low", ser_tx, 0);
    resetb = 1'b0;
    #1;
    check("rstmid_ser_tx", ser_tx, 1);
    check("rstmid_level", fifo_level, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_ready", tx_ready, 1);
    @(negedge clock);
    resetb = 1'b1;
    r0 = ser_q.size();
    wait_samples(r0 + 200);
    lows = 0;
    busys = 0;
    for (int i = r0; i < r0 + 200 && i < ser_q.size(); i++) begin
      if (ser_q[i] !== 1'b1) lows++;
      if (busy_q[i] !== 1'b0) busys++;
    end
    check("rstmid_line_low_cycles_after_release", lows, 0);
    check("rstmid_busy_cycles_after_release", busys, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snn_uart_tx.md
Name: snn_uart_tx

Overview:
- Synthesizable 8-bit asynchronous serial transmitter with a small transmit FIFO.
- Lives in the user project area. Firmware or SNN status logic pushes bytes into it, and it serialises them onto an mprj_io pin.
- It is the transmitting counterpart to the testbench UART receiver (tbuart) that decodes the chip's serial output.
- Frame format: 8N1, LSB first, with a runtime-programmable bit period.

Parameters:
- FIFO_DEPTH, 4, number of byte entries in the transmit FIFO; must be a power of 2 and at least 2.
- DIV_WIDTH, 16, width of the baud divisor input.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- resetb  input  1  asynchronous active-low reset.
- cfg_div  input  DIV_WIDTH  clock cycles per serial bit.
- tx_data  input  8  byte to transmit.
- tx_valid  input  1  tx_data is valid this cycle.
- tx_ready  output  1  FIFO can accept a byte this cycle.
- ser_tx  output  1  serial line, idle high.
- busy  output  1  a frame is in progress or the FIFO is non-empty.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of bytes held in the FIFO.

Behaviour:
- Reset (resetb low, asynchronous):
  - Outputs: ser_tx=1, tx_ready=1, busy=0, fifo_level=0.
  - FIFO pointers cleared and FSM forced to IDLE.
  - A frame in flight is aborted; the line returns high immediately.
  - Release is used synchronously; no byte is sent after release unless pushed again.
- Push:
  - A byte is accepted on a rising edge when tx_valid && tx_ready.
  - tx_ready = (fifo_level != FIFO_DEPTH), decoded from registered state.
  - When full, tx_ready=0 even if a pop occurs the same cycle; there is no full-bypass path.
  - Pushing with tx_valid while tx_ready=0 is ignored and is not an error.
- Pop: the FSM pops in IDLE when the FIFO is non-empty. A simultaneous push and pop leaves fifo_level unchanged.
- Bit period and divisor:
  - Effective period P = max(cfg_div, 2) clock cycles; cfg_div=0 or 1 is treated as 2.
  - cfg_div is latched into an internal register at frame start. Changes mid-frame affect only the next frame.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: ser_tx=1. If the FIFO is non-empty: pop the head into the shift register, load bit counter 0, load baud counter P-1, go to START.
  - START: ser_tx=0 for P cycles, then go to DATA.
  - DATA: ser_tx = shift[0] for P cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: ser_tx=1 for P cycles, then return to IDLE.
- Frame timing:
  - IDLE evaluates and transitions on the same edge that ends STOP. Back-to-back bytes therefore produce exactly 10*P cycles per frame, with no idle gap.
  - Latency: a byte accepted at edge E0 into an empty FIFO while in IDLE drives ser_tx low after edge E1, i.e. 1 cycle later.
- ser_tx is registered; it is never driven by combinational logic.
- busy = (state != IDLE) || (fifo_level != 0).
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_level is tracked as a separate counter, not derived from pointer difference.

Optional Feature:
- Macro: SNN_UART_TX_PARITY_EN.
- When defined:
  - Adds input port cfg_parity_odd (1 bit), latched at frame start like cfg_div.
  - Adds a PARITY state between DATA and STOP.
  - The parity bit is the XOR of the 8 data bits; it is inverted when cfg_parity_odd=1.
  - The parity bit lasts P cycles, making a frame 11*P cycles.
- When undefined: no extra port and no PARITY state; frames are 10*P cycles.

Test Plan:
- Reset mid-frame: cfg_div=4, push 0xA5, assert resetb low during DATA bit 3 → ser_tx=1 immediately, fifo_level=0, busy=0. After release, the line stays high for 200 cycles.
- Single byte: cfg_div=4, push 0xA5 → after 1 cycle, ser_tx = 0, then 1,0,1,0,0,1,0,1, then 1. Each bit lasts 4 cycles, the frame is 40 cycles, and busy falls on the cycle after the stop bit ends.
- Back-to-back and full:
  - cfg_div=8, FIFO_DEPTH=4, push 0x00,0xFF,0x55,0x0F,0xF0 on consecutive cycles.
  - The first is popped immediately, so all 5 are accepted; tx_ready drops only once fifo_level reaches 4.
  - Five contiguous 80-cycle frames follow with no idle gap.
- Divisor clamp: cfg_div=0 → bit period 2 cycles. Changing cfg_div from 4 to 6 during a frame → the current frame stays at 4, the next frame uses 6.
- Simultaneous push and pop: with 1 byte queued and FSM in IDLE, push on the pop edge → fifo_level stays 1 and both bytes are transmitted in order.
- Parity (SNN_UART_TX_PARITY_EN defined), cfg_div=4:
  - Push 0x03 with even parity (cfg_parity_odd=0) → parity bit 0.
  - Push 0x07 with odd parity (cfg_parity_odd=1) → parity bit 0.
  - Each frame is 44 cycles.
